// File: rtl/codificador_teclado_if.sv
// Scan-code byte input and key-enable outputs between the PS/2 receiver,
// the scan-code encoder and the keyboard decoder stage.
interface codificador_teclado_if;
  logic [7:0] code;
  logic       code_valid;
  logic [4:0] enable;
  logic       key_event;
  logic       proto_err;

  modport master (
    output code,
    output code_valid,
    input  enable,
    input  key_event,
    input  proto_err
  );

  modport slave (
    input  code,
    input  code_valid,
    output enable,
    output key_event,
    output proto_err
  );
endinterface

// File: rtl/codificador_teclado.sv
// PS/2 scan-code encoder: tracks E0/F0 prefixes and holds one enable bit per
// mapped key while it is pressed; flags illegal prefix sequences and stale prefixes.
module codificador_teclado #(
  parameter logic [7:0]  KEY_ALARM  = 8'h1C,
  parameter logic [7:0]  KEY_UP     = 8'h75,
  parameter logic [7:0]  KEY_DOWN   = 8'h72,
  parameter logic [7:0]  KEY_LEFT   = 8'h6B,
  parameter logic [7:0]  KEY_RIGHT  = 8'h74,
  parameter int unsigned PREFIX_TMO = 50000
) (
  input logic                  clk,
  input logic                  reset_n,
  codificador_teclado_if.slave kbd
);

  localparam logic [7:0]  PrefixExt = 8'hE0;
  localparam logic [7:0]  PrefixBrk = 8'hF0;
  localparam int unsigned CntW      = (PREFIX_TMO > 2) ? $clog2(PREFIX_TMO) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(PREFIX_TMO - 1);

  typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} state_e;

  state_e          state_q, state_d;
  logic [4:0]      enable_q, enable_d;
  logic            key_event_q, key_event_d;
  logic            proto_err_q, proto_err_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      arrow;
  logic            is_prefix;

  // One-hot arrow position for the incoming byte; zero when it is not an arrow.
  always_comb begin
    arrow = 4'b0000;
    if (kbd.code == KEY_UP)    arrow = 4'b0001;
    if (kbd.code == KEY_DOWN)  arrow = 4'b0010;
    if (kbd.code == KEY_LEFT)  arrow = 4'b0100;
    if (kbd.code == KEY_RIGHT) arrow = 4'b1000;
  end

  assign is_prefix = (kbd.code == PrefixExt) || (kbd.code == PrefixBrk);

  always_comb begin
    state_d     = state_q;
    enable_d    = enable_q;
    cnt_d       = cnt_q;
    proto_err_d = 1'b0;

    if (kbd.code_valid) begin
      cnt_d = '0;
      unique case (state_q)
        StIdle: begin
          if (kbd.code == PrefixExt) begin
            state_d = StExt;
          end else if (kbd.code == PrefixBrk) begin
            state_d = StBrk;
          end else if (kbd.code == KEY_ALARM) begin
            enable_d[4] = 1'b1;
          end
        end
        StExt: begin
          if (kbd.code == PrefixBrk) begin
            state_d = StExtBrk;
          end else if (kbd.code == PrefixExt) begin
            state_d = StExt;
          end else begin
            state_d       = StIdle;
            enable_d[3:0] = enable_q[3:0] | arrow;
          end
        end
        StBrk: begin
          state_d = StIdle;
          if (kbd.code == KEY_ALARM) begin
            enable_d[4] = 1'b0;
          end else if (is_prefix) begin
            proto_err_d = 1'b1;
          end
        end
        StExtBrk: begin
          state_d = StIdle;
          if (is_prefix) begin
            proto_err_d = 1'b1;
          end else begin
            enable_d[3:0] = enable_q[3:0] & ~arrow;
          end
        end
        default: state_d = StIdle;
      endcase
    end else if (state_q != StIdle) begin
      // Expiry resets the counter, so it can never pass CntLast or wrap.
      if (cnt_q == CntLast) begin
        state_d     = StIdle;
        proto_err_d = 1'b1;
        cnt_d       = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    key_event_d = |(enable_d & ~enable_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      enable_q    <= 5'b0;
      key_event_q <= 1'b0;
      proto_err_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      enable_q    <= enable_d;
      key_event_q <= key_event_d;
      proto_err_q <= proto_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign kbd.enable    = enable_q;
  assign kbd.key_event = key_event_q;
  assign kbd.proto_err = proto_err_q;

endmodule

// File: tb/tb_codificador_teclado.sv
// Scoreboard bench for codificador_teclado: directed byte sequences push expected
// output events; a negedge monitor pops and compares whenever the outputs change or pulse.
module tb_codificador_teclado;

  localparam int unsigned Tmo = 20;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int unsigned cyc = 0;
  int unsigned last_cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [4:0]  en;
    logic        ke;
    logic        pe;
    int unsigned due;
    string       name;
  } exp_t;

  exp_t q[$];

  codificador_teclado_if kbd ();

  codificador_teclado #(
    .PREFIX_TMO(Tmo)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .kbd    (kbd.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Drive one byte for exactly one cycle; entered and left at #1 after a posedge.
  task automatic send(input logic [7:0] b);
    kbd.code       = b;
    kbd.code_valid = 1'b1;
    last_cyc       = cyc;
    @(posedge clk);
    #1;
    kbd.code_valid = 1'b0;
    kbd.code       = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_evt(input string name, input logic [4:0] en, input logic ke,
                            input logic pe, input int unsigned due);
    exp_t e;
    e.en = en; e.ke = ke; e.pe = pe; e.due = due; e.name = name;
    q.push_back(e);
  endtask

  // Monitor: an event is any enable change or any pulse on key_event/proto_err.
  initial begin
    logic [4:0] prev;
    exp_t e;
    prev = 5'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev = kbd.enable;
      end else if ((kbd.enable !== prev) || (kbd.key_event !== 1'b0) ||
                   (kbd.proto_err !== 1'b0)) begin
        prev = kbd.enable;
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_event: got enable=%b ke=%b pe=%b at cycle %0d, expected none",
                   kbd.enable, kbd.key_event, kbd.proto_err, cyc);
        end else begin
          e = q.pop_front();
          chk({e.name, "_out"}, {25'b0, kbd.enable, kbd.key_event, kbd.proto_err},
              {25'b0, e.en, e.ke, e.pe});
          chk({e.name, "_cycle"}, cyc, e.due);
        end
      end
    end
  end

  initial begin
    int unsigned t0;
    kbd.code       = 8'h00;
    kbd.code_valid = 1'b0;

    // Reset with random input activity
    for (int i = 0; i < 4; i++) begin
      #1;
      kbd.code       = 8'($urandom);
      kbd.code_valid = 1'($urandom);
      @(posedge clk);
    end
    #1;
    chk("reset_enable", {27'b0, kbd.enable}, 32'h0);
    chk("reset_key_event", {31'b0, kbd.key_event}, 32'h0);
    chk("reset_proto_err", {31'b0, kbd.proto_err}, 32'h0);
    kbd.code_valid = 1'b0;
    reset_n = 1'b1;
    idle(2);

    // Alarm make / break
    send(8'h1C); expect_evt("alarm_make", 5'b10000, 1'b1, 1'b0, last_cyc + 1);
    idle(2);
    send(8'hF0); send(8'h1C); expect_evt("alarm_break", 5'b00000, 1'b0, 1'b0, last_cyc + 1);
    idle(2);

    // Extended arrows
    send(8'hE0); send(8'h75); expect_evt("up_make", 5'b00001, 1'b1, 1'b0, last_cyc + 1);
    send(8'hE0); send(8'h74); expect_evt("right_make", 5'b01001, 1'b1, 1'b0, last_cyc + 1);
    send(8'hE0); send(8'hF0); send(8'h75);
    expect_evt("up_break", 5'b01000, 1'b0, 1'b0, last_cyc + 1);
    idle(2);

    // Typematic repeat, unmapped codes, repeated E0, break of an unset key
    send(8'h1C); expect_evt("alarm_repeat", 5'b11000, 1'b1, 1'b0, last_cyc + 1);
    for (int i = 0; i < 4; i++) send(8'h1C);
    send(8'h75);
    send(8'hE0); send(8'h1C);
    send(8'hE0); send(8'hE0); send(8'h72);
    expect_evt("down_after_e0e0", 5'b11010, 1'b1, 1'b0, last_cyc + 1);
    send(8'hE0); send(8'hF0); send(8'h6B);
    idle(2);

    // Protocol errors and recovery
    send(8'hF0); send(8'h1C); expect_evt("alarm_break2", 5'b01010, 1'b0, 1'b0, last_cyc + 1);
    send(8'hF0); send(8'hF0); expect_evt("f0_f0_err", 5'b01010, 1'b0, 1'b1, last_cyc + 1);
    send(8'h1C); expect_evt("alarm_recover", 5'b11010, 1'b1, 1'b0, last_cyc + 1);
    send(8'hE0); send(8'hF0); send(8'hE0);
    expect_evt("e0_f0_e0_err", 5'b11010, 1'b0, 1'b1, last_cyc + 1);
    idle(2);

    // Byte arriving on the expiry cycle wins over the timeout
    send(8'hE0);
    idle(Tmo - 1);
    send(8'h75); expect_evt("valid_beats_tmo", 5'b11011, 1'b1, 1'b0, last_cyc + 1);
    idle(2);

    // Timeout after E0, then a bare arrow is ignored
    send(8'hE0);
    t0 = last_cyc;
    expect_evt("ext_timeout", 5'b11011, 1'b0, 1'b1, t0 + 1 + Tmo);
    idle(Tmo + 2);
    send(8'h75);
    idle(2);

    // Timeout after F0
    send(8'hF0);
    t0 = last_cyc;
    expect_evt("brk_timeout", 5'b11011, 1'b0, 1'b1, t0 + 1 + Tmo);
    idle(Tmo + 2);

    // Reset mid-sequence clears enables and the pending prefix
    send(8'hE0);
    reset_n = 1'b0;
    #1;
    chk("midreset_enable", {27'b0, kbd.enable}, 32'h0);
    chk("midreset_key_event", {31'b0, kbd.key_event}, 32'h0);
    chk("midreset_proto_err", {31'b0, kbd.proto_err}, 32'h0);
    idle(2);
    reset_n = 1'b1;
    idle(1);
    send(8'h75);
    send(8'h1C); expect_evt("alarm_after_reset", 5'b10000, 1'b1, 1'b0, last_cyc + 1);
    idle(5);

    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL %s: got no event, expected enable=%b ke=%b pe=%b at cycle %0d",
               e.name, e.en, e.ke, e.pe, e.due);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
